// File: rtl/stft_pkg.sv
// Shared STFT definitions: default sizes, complex word type, saturation limits.
// Used by twiddle_multiplier and complex_mult (TWIDDLE_ROUND_EN selects rounding).
package stft_pkg;

    localparam int STFT_N = 32;
    localparam int STFT_W = 16;
    localparam int IDX_W  = $clog2(STFT_N);

    localparam logic signed [STFT_W-1:0] SAT_MAX = {1'b0, {(STFT_W-1){1'b1}}};
    localparam logic signed [STFT_W-1:0] SAT_MIN = {1'b1, {(STFT_W-1){1'b0}}};

    typedef struct packed {
        logic signed [STFT_W-1:0] re;
        logic signed [STFT_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/complex_mult.sv
// Two-stage complex multiply: products, then combine/shift/saturate.
// Macro TWIDDLE_ROUND_EN adds a half-LSB before the shift (round-half-up).
import stft_pkg::*;

module complex_mult #(
    parameter int W  = STFT_W,
    parameter int IW = IDX_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            in_valid,
    input  logic [2*W-1:0]  sample,
    input  logic [2*W-1:0]  twiddle,
    input  logic            in_last,
    input  logic [IW-1:0]   in_index,
    output logic            out_valid,
    output logic [2*W-1:0]  out_data,
    output logic            out_last,
    output logic [IW-1:0]   out_index
);

    localparam logic signed [2*W:0] SMAX = (2*W+1)'((2**(W-1)) - 1);
    localparam logic signed [2*W:0] SMIN = -(2*W+1)'(2**(W-1));
    localparam logic signed [2*W:0] RND  = (2*W+1)'(2**(W-2));

    logic signed [W-1:0]   a, b, c, d;
    logic signed [2*W-1:0] ac, bd, ad, bc;
    logic                  s2_valid;
    logic                  s2_last;
    logic [IW-1:0]         s2_index;
    logic signed [2*W:0]   re_sum, im_sum;
    logic signed [2*W:0]   re_sh, im_sh;
    logic [W-1:0]          re_sat, im_sat;

    assign a = sample[2*W-1:W];
    assign b = sample[W-1:0];
    assign c = twiddle[2*W-1:W];
    assign d = twiddle[W-1:0];

    function automatic logic [W-1:0] sat(input logic signed [2*W:0] v);
        logic signed [2*W:0] r;
        r = v;
        if (v > SMAX) r = SMAX;
        else if (v < SMIN) r = SMIN;
        return r[W-1:0];
    endfunction

    // S2: register the four partial products alongside valid/last/index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_index <= '0;
            ac       <= '0;
            bd       <= '0;
            ad       <= '0;
            bc       <= '0;
        end else if (en) begin
            s2_valid <= in_valid;
            s2_last  <= in_last;
            s2_index <= in_index;
            ac       <= a * c;
            bd       <= b * d;
            ad       <= a * d;
            bc       <= b * c;
        end
    end

    // S3 datapath: widen, combine, optionally round, scale back to Q1.(W-1)
    always_comb begin
        re_sum = (2*W+1)'(ac) - (2*W+1)'(bd);
        im_sum = (2*W+1)'(ad) + (2*W+1)'(bc);
`ifdef TWIDDLE_ROUND_EN
        re_sum = re_sum + RND;
        im_sum = im_sum + RND;
`else
        re_sum = re_sum + (RND & '0);
        im_sum = im_sum + (RND & '0);
`endif
        re_sh  = re_sum >>> (W-1);
        im_sh  = im_sum >>> (W-1);
        re_sat = sat(re_sh);
        im_sat = sat(im_sh);
    end

    // S3: register the saturated result; held while the pipeline stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_index <= '0;
        end else if (en) begin
            out_valid <= s2_valid;
            out_data  <= {re_sat, im_sat};
            out_last  <= s2_last;
            out_index <= s2_index;
        end
    end

endmodule

// File: rtl/twiddle_multiplier.sv
// Streaming sample x twiddle stage: frame index, ROM addressing, capture, handshake.
// Macro TWIDDLE_ROUND_EN selects round-half-up scaling in complex_mult.
import stft_pkg::*;

module twiddle_multiplier #(
    parameter int N         = STFT_N,
    parameter int word_size = STFT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*word_size-1:0] in_data,
    input  logic                   in_last,
    output logic [$clog2(N)-1:0]   read_address,
    input  logic [2*word_size-1:0] twiddle,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*word_size-1:0] out_data,
    output logic                   out_last,
    output logic [$clog2(N)-1:0]   out_index
);

    localparam int AW = $clog2(N);

    logic                   en;
    logic                   accept;
    logic [AW-1:0]          idx;
    logic                   s1_valid;
    logic                   s1_last;
    logic [AW-1:0]          s1_index;
    logic [2*word_size-1:0] s1_sample;
    logic [2*word_size-1:0] s1_twiddle;

    assign en           = !out_valid || out_ready;
    assign in_ready     = en;
    assign accept       = in_valid && en;
    assign read_address = idx;

    // Frame index: advance per accepted sample, restart on last or at N-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (accept) begin
            if (in_last || idx == AW'(N-1)) idx <= '0;
            else idx <= idx + 1'b1;
        end
    end

    // S1: capture sample, the twiddle seen this cycle, last flag and index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_index   <= '0;
            s1_sample  <= '0;
            s1_twiddle <= '0;
        end else if (en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_last    <= in_last;
                s1_index   <= idx;
                s1_sample  <= in_data;
                s1_twiddle <= twiddle;
            end
        end
    end

    complex_mult #(
        .W  (word_size),
        .IW (AW)
    ) u_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (s1_valid),
        .sample    (s1_sample),
        .twiddle   (s1_twiddle),
        .in_last   (s1_last),
        .in_index  (s1_index),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_index (out_index)
    );

endmodule

// File: tb/tb_twiddle_multiplier.sv
// Self-checking bench for twiddle_multiplier with an arithmetic reference model.
// Build with TWIDDLE_ROUND_EN defined to check the rounding variant.
module tb_twiddle_multiplier;

    localparam int N = 32;
    localparam int W = 16;

`ifdef TWIDDLE_ROUND_EN
    localparam logic [31:0] ID_EXP = 32'h1000F000;
`else
    localparam logic [31:0] ID_EXP = 32'h0FFFF000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [4:0]  read_address;
    logic [31:0] twiddle;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic [4:0]  out_index;

    logic [31:0] rom [N];

    always #5 clk = ~clk;

    assign twiddle = rom[read_address];

    twiddle_multiplier #(.N(N), .word_size(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .read_address (read_address),
        .twiddle      (twiddle),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_index    (out_index)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          idx;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          nvec = 0;
    int          nerr = 0;
    int          midx = 0;
    int          cyc = 0;
    int          last_lat = 0;
    logic [31:0] last_out = '0;
    logic        hold = 1'b0;
    logic [31:0] h_data;
    logic        h_last;
    logic [4:0]  h_idx;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input longint v);
        longint r;
        r = v;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    // Complex product in Q1.15, computed with plain integer arithmetic.
    function automatic logic [31:0] ref_mul(input logic [31:0] s,
                                            input logic [31:0] t);
        longint a, b, c, d, re, im;
        a = longint'($signed(s[31:16]));
        b = longint'($signed(s[15:0]));
        c = longint'($signed(t[31:16]));
        d = longint'($signed(t[15:0]));
        re = a * c - b * d;
        im = a * d + b * c;
`ifdef TWIDDLE_ROUND_EN
        re = re + 16384;
        im = im + 16384;
`endif
        re = re >>> 15;
        im = im >>> 15;
        return {sat16(re), sat16(im)};
    endfunction

    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (hold) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(h_data));
                chk("hold_last", 64'(out_last), 64'(h_last));
                chk("hold_index", 64'(out_index), 64'(h_idx));
            end
            hold   = out_valid && !out_ready;
            h_data = out_data;
            h_last = out_last;
            h_idx  = out_index;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.data));
                    chk("out_last", 64'(out_last), 64'(e.last));
                    chk("out_index", 64'(out_index), 64'(e.idx));
                    last_out = out_data;
                    last_lat = cyc - e.cyc;
                end
            end
            if (in_valid && in_ready) begin
                chk("read_address", 64'(read_address), 64'(midx));
                e.data = ref_mul(in_data, rom[midx]);
                e.last = in_last;
                e.idx  = midx;
                e.cyc  = cyc;
                q.push_back(e);
                midx = (in_last || midx == N - 1) ? 0 : midx + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) rom[i] = '0;

        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_index", 64'(out_index), 64'd0);
        chk("rst_read_address", 64'(read_address), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        rom[0] = 32'h7FFF0000;
        rom[1] = 32'h00008000;
        rom[2] = 32'h80008000;
        send(32'h1000F000, 1'b0);
        idle(4);
        chk("identity", 64'(last_out), 64'(ID_EXP));
        chk("latency", 64'(last_lat), 64'd3);
        send(32'h01000200, 1'b0);
        idle(4);
        chk("minus_j", 64'(last_out), 64'h0200FF00);
        send(32'h80008000, 1'b0);
        idle(4);
        chk("saturate", 64'(last_out), 64'h00007FFF);

        send($urandom, 1'b0);
        send($urandom, 1'b0);
        send($urandom, 1'b1);
        chk("early_last_addr", 64'(read_address), 64'd0);
        idle(4);
        chk("early_last_out", 64'(last_out[0] === 1'bx), 64'd0);

        for (int i = 0; i < N; i++) rom[i] = $urandom;
        for (int i = 0; i < 2 * N; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_last  = 1'b0;
            step();
        end
        in_valid = 1'b0;
        idle(4);
        chk("wrap_end_addr", 64'(read_address), 64'd0);

        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            in_last   = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        idle(5);

        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom;
            step();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = $urandom;
            step();
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = $urandom;
            step();
        end

        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_addr", 64'(read_address), 64'd0);
        q.delete();
        midx = 0;
        hold = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom;
            step();
        end
        in_valid = 1'b0;
        idle(5);
        chk("drained", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/twiddle_multiplier.md
# twiddle_multiplier

Streaming complex-by-twiddle multiply stage that sits directly downstream of `twiddleROM` in the STFT path. It accepts windowed complex samples on a valid/ready stream and drives the ROM `read_address` from an internal per-frame index counter. It multiplies each sample by the combinational ROM word and emits the scaled, saturated complex product on a valid/ready stream to the next FFT stage.

## Interface
- `N`, 32: frame length and ROM depth; power of two, ≥ 4.
- `word_size`, 16: width of each real/imag component, signed two's complement; twiddles are Q1.(word_size-1).
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `in_valid` input 1: input sample valid.
- `in_ready` output 1: block can accept a sample this cycle.
- `in_data` input 2*word_size: {re[2w-1:w], im[w-1:0]}.
- `in_last` input 1: final sample of the frame.
- `read_address` output $clog2(N): ROM index, equal to the current frame index counter.
- `twiddle` input 2*word_size: ROM word {re, im}, combinational from `read_address`.
- `out_valid` output 1: product valid.
- `out_ready` input 1: downstream accepts.
- `out_data` output 2*word_size: {re, im} product.
- `out_last` output 1: `in_last` delayed alongside its sample.
- `out_index` output $clog2(N): frame index of the sample on `out_data`.

## Operation
- The handshake is accepted when `in_valid && in_ready`.
- Index counter `idx`:
  - Reset value 0.
  - Increments on each accepted sample.
  - Returns to 0 after an accepted sample with `in_last=1`, or after an accepted sample at `idx==N-1` (wrap), whichever occurs first.
  - `read_address = idx` at all times.
- Stage S1 (capture): on accept, register `in_data`, `twiddle`, `in_last` and `idx`. The twiddle used is the value present in the accept cycle.
- Stage S2 (multiply): compute four signed products, each 2w bits: ac, bd, ad, bc.
- Stage S3 (combine/scale):
  - re = ac − bd; im = ad + bc; each is 2w+1 bits.
  - Arithmetic shift right by w−1.
  - Saturate to [−2^(w−1), 2^(w−1)−1].
- Pipeline enable `en = !out_valid || out_ready`. All stages advance together when `en=1` and hold when `en=0`.
- `in_ready = en`. Each stage valid bit propagates with its data, so bubbles pass through as invalid slots.
- `out_data`, `out_last` and `out_index` are stable while `out_valid && !out_ready`.

## Timing
- Latency is 3 cycles from accept to `out_valid` with no stall.
- Throughput is 1 sample/cycle.
- Reset values (asynchronous, while `rst_n=0`):
  - `out_valid=0`, `out_data=0`, `out_last=0`, `out_index=0`.
  - `idx=0`, so `read_address=0`.
  - All stage valids 0.
- Reset mid-frame discards all in-flight samples. The first accept after release uses index 0.
- `in_ready` depends only on registered `out_valid` and `out_ready`. There is no combinational path from `in_valid` to `in_ready`.
- `in_last` together with `idx==N-1`: a single wrap to 0, not a double increment.
- `in_valid=0` leaves `idx` unchanged, so the index is not lost across gaps.

## Configuration
- Macro: `TWIDDLE_ROUND_EN`.
- Defined: add 2^(w−2) before the shift (round-half-up), then saturate.
- Undefined: truncate (floor) on the shift, then saturate.
- Latency is identical in both builds.

## Structure
- Shared package `stft_pkg`:
  - Complex word typedef {re, im} of `word_size`.
  - Index width localparam $clog2(N).
  - Saturation limits as localparams.
- One sub-module `complex_mult`:
  - Covers S2–S3: the signed products, combine, round/shift and saturate.
  - Clock-enabled by `en`, with a 2-cycle latency.
- The top level holds `idx`, S1 and the handshake.

## Test plan
- **Identity multiply:** w=16, twiddle={0x7FFF, 0x0000}, sample {0x1000, 0xF000}. Required response after 3 cycles:
  - `out_data={0x0FFF, 0xF000}` (truncate).
  - With `TWIDDLE_ROUND_EN`: {0x1000, 0xF000}.
- **−j twiddle:** twiddle={0x0000, 0x8000}, sample {0x0100, 0x0200}. Required response:
  - re = −(0x0200·−0x8000) ≫ 15 = 0x0200.
  - im = 0x0100·−0x8000 ≫ 15 = 0xFF00.
- **Saturation:** sample {0x8000, 0x8000}, twiddle {0x8000, 0x8000}. Required response:
  - re = 0.
  - im = 2^31 ≫ 15 = 0x10000, which saturates to 0x7FFF.
- **Index wrap:** stream 2N samples, never assert `in_last`. Required response:
  - `read_address` steps 0..N−1, 0..N−1.
  - `out_index` mirrors it 3 cycles later.
- **Early last:** assert `in_last` at idx=5. Required response:
  - The next accept drives `read_address=0`.
  - `out_last=1` only on the index-5 output.
- **Backpressure and reset:**
  - Hold `out_ready=0` for 4 cycles with continuous input. Required response: `in_ready=0` once `out_valid=1`, data held stable, no sample dropped or duplicated on release.
  - Then pulse `rst_n=0` mid-stream. Required response: immediately `out_valid=0` and `read_address=0`.
